// File: rtl/idu_ctrl.sv
`default_nettype none
// idu_ctrl: RV64 decode-stage controller. Single-entry stage register between IFU and EXU,
// classifies the opcode for the immediate extender and halts the front end on ebreak/illegal.
module idu_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  input  logic [63:0]      pc,
  input  logic             flush,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_inst,
  output logic [63:0]      dec_pc,
  output logic [2:0]       imm_type,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             rd_we,
  output logic [1:0]       halt_code,
  output logic             halted,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  state_t           state, state_nxt;
  logic [31:0]      inst_q;
  logic [63:0]      pc_q;
  logic [2:0]       imm_q;
  logic             rd_we_q;
  logic [1:0]       hc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]       imm_d;
  logic             rd_we_d;
  logic [1:0]       hc_d;
  logic             rd_nz;
  logic             fire;
  logic             xfer;

  // Decode of the incoming word; the result is captured together with the entry.
  always_comb begin
    imm_d   = IMM_NONE;
    rd_we_d = 1'b0;
    hc_d    = 2'd0;
    rd_nz   = (inst[11:7] != 5'd0);
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin
        imm_d   = IMM_U;
        rd_we_d = rd_nz;
      end
      7'b1101111: begin
        imm_d   = IMM_J;
        rd_we_d = rd_nz;
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
        imm_d   = IMM_I;
        rd_we_d = rd_nz;
      end
      7'b1100011: imm_d = IMM_B;
      7'b0100011: imm_d = IMM_S;
      7'b0110011, 7'b0111011: rd_we_d = rd_nz;
      7'b1110011: begin
        imm_d = IMM_I;
        if (inst == 32'h0010_0073) hc_d = 2'd1;
      end
      default: hc_d = 2'd2;
    endcase
  end

  // Handshakes are masked by rst and flush so neither a fire nor an xfer can slip through.
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    dec_valid  = 1'b0;
    if (!rst && !flush) begin
      case (state)
        EMPTY:   inst_ready = 1'b1;
        FULL: begin
          dec_valid  = 1'b1;
          inst_ready = dec_ready & (hc_q == 2'd0);
        end
        default: ;
      endcase
    end
    fire = inst_valid & inst_ready;
    xfer = dec_valid & dec_ready;
    case (state)
      EMPTY: if (fire) state_nxt = FULL;
      FULL: begin
        if (xfer) begin
          if (hc_q != 2'd0) state_nxt = HALT;
          else if (fire)    state_nxt = FULL;
          else              state_nxt = EMPTY;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = EMPTY;
    endcase
    if (flush && state != HALT) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      inst_q  <= '0;
      pc_q    <= '0;
      imm_q   <= IMM_NONE;
      rd_we_q <= 1'b0;
      hc_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        inst_q  <= inst;
        pc_q    <= pc;
        imm_q   <= imm_d;
        rd_we_q <= rd_we_d;
        hc_q    <= hc_d;
      end
      if (xfer) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dec_inst  = inst_q;
  assign dec_pc    = pc_q;
  assign imm_type  = imm_q;
  assign rd        = inst_q[11:7];
  assign rs1       = inst_q[19:15];
  assign rs2       = inst_q[24:20];
  assign rd_we     = rd_we_q;
  assign halt_code = hc_q;
  assign halted    = (state == HALT);
  assign issue_cnt = cnt_q;

endmodule
`default_nettype wire
